// File: rtl/scroll_char_buf.sv
// scroll_char_buf: circular text buffer fed by a character stream, with a
// one-cycle pixel read port for a text-mode display.
// Configuration macro: SCROLL_CHAR_BUF_CURSOR_BLINK_EN (cursor blinking).
// The glyph ROM is a compact stand-in: rows 2..13, columns 0..6 of a glyph
// show bit <column> of the character code; other pixels are dark.
module scroll_char_buf #(
    parameter int p_num_rows     = 16,
    parameter int p_num_cols     = 32,
    parameter int p_tab_width    = 4,
    parameter int p_blink_period = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_ascii,
    input  logic [3:0] in_attr,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [6:0] read_hchar,
    input  logic [4:0] read_vchar,
    input  logic [2:0] read_hoffset,
    input  logic [3:0] read_voffset,
    output logic       read_lit,
    output logic [3:0] read_attr,
    output logic       out_of_bounds
);

    localparam int lp_rw = $clog2(p_num_rows);
    localparam int lp_cw = $clog2(p_num_cols);
    localparam logic [lp_rw-1:0] lp_last_row = lp_rw'(p_num_rows - 1);
    localparam logic [lp_cw-1:0] lp_last_col = lp_cw'(p_num_cols - 1);
    localparam logic [lp_rw:0]   lp_rows_w   = (lp_rw + 1)'(p_num_rows);
    localparam logic [lp_cw:0]   lp_cols_w   = (lp_cw + 1)'(p_num_cols);
    localparam logic [lp_cw:0]   lp_tab_mask = (lp_cw + 1)'(p_tab_width - 1);
    localparam logic [7:0]       lp_cols_8   = 8'(p_num_cols);
    localparam logic [5:0]       lp_rows_6   = 6'(p_num_rows);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state_r;
    logic [lp_rw-1:0] clr_row_r;
    logic [lp_cw-1:0] cur_x_r;
    logic [lp_rw-1:0] cur_y_r;
    logic [lp_rw-1:0] top_r;
    logic             in_rdy_r;
    logic             read_lit_r;
    logic [3:0]       read_attr_r;
    logic             oob_r;

    // cell = {ascii[7:0], attr[3:0]}; zero means empty
    logic [11:0] mem_r [p_num_rows][p_num_cols];

    logic             accept_s;
    logic             cursor_vis_s;
    logic [lp_rw-1:0] cur_phys_s;
    logic [lp_cw:0]   tab_nxt_s;
    logic             wr_en_s;
    logic [lp_cw-1:0] wr_col_s;
    logic [11:0]      wr_data_s;
    logic             zero_en_s;
    logic [lp_rw-1:0] zero_row_s;
    logic [lp_cw-1:0] x_nxt_s;
    logic [lp_rw-1:0] y_nxt_s;
    logic [lp_rw-1:0] top_nxt_s;
    logic             adv_s;
    logic             esc_s;
    logic             oob_s;
    logic [lp_rw-1:0] rd_row_s;
    logic [11:0]      rd_cell_s;
    logic             hit_s;

    // logical row to physical row, modulo the row count
    function automatic logic [lp_rw-1:0] phys_row(input logic [lp_rw-1:0] lrow,
                                                  input logic [lp_rw-1:0] top);
        logic [lp_rw:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= lp_rows_w) begin
            sum = sum - lp_rows_w;
        end else begin
            sum = sum;
        end
        return sum[lp_rw-1:0];
    endfunction

    // glyph pixel lookup; code 0 has no set bits so empty cells stay dark
    function automatic logic char_lut(input logic [7:0] code, input logic [2:0] hoff,
                                      input logic [3:0] voff);
        if (voff >= 4'd2 && voff <= 4'd13 && hoff != 3'd7) begin
            return code[hoff];
        end else begin
            return 1'b0;
        end
    endfunction

    assign accept_s   = in_val && in_rdy_r;
    assign cur_phys_s = phys_row(cur_y_r, top_r);
    assign tab_nxt_s  = ({1'b0, cur_x_r} | lp_tab_mask) + {{lp_cw{1'b0}}, 1'b1};
    assign in_rdy        = in_rdy_r;
    assign read_lit      = read_lit_r;
    assign read_attr     = read_attr_r;
    assign out_of_bounds = oob_r;

`ifdef SCROLL_CHAR_BUF_CURSOR_BLINK_EN
    localparam int lp_bw = (p_blink_period > 1) ? $clog2(p_blink_period) : 1;
    localparam logic [lp_bw-1:0] lp_blink_last = lp_bw'(p_blink_period - 1);
    logic [lp_bw-1:0] blink_cnt_r;
    logic             cursor_vis_r;

    // blink timer; typing restarts it with the cursor shown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r  <= {lp_bw{1'b0}};
            cursor_vis_r <= 1'b1;
        end else if (accept_s) begin
            blink_cnt_r  <= {lp_bw{1'b0}};
            cursor_vis_r <= 1'b1;
        end else if (blink_cnt_r == lp_blink_last) begin
            blink_cnt_r  <= {lp_bw{1'b0}};
            cursor_vis_r <= ~cursor_vis_r;
        end else begin
            blink_cnt_r  <= blink_cnt_r + {{(lp_bw-1){1'b0}}, 1'b1};
        end
    end
    assign cursor_vis_s = cursor_vis_r;
`else
    logic [31:0] unused_blink_s;
    assign unused_blink_s = 32'(p_blink_period);
    assign cursor_vis_s   = 1'b1;
`endif

    // decode the accepted character into a cell write, row zeroing and cursor motion
    always_comb begin
        wr_en_s    = 1'b0;
        wr_col_s   = cur_x_r;
        wr_data_s  = 12'h000;
        zero_en_s  = 1'b0;
        zero_row_s = clr_row_r;
        x_nxt_s    = cur_x_r;
        y_nxt_s    = cur_y_r;
        top_nxt_s  = top_r;
        adv_s      = 1'b0;
        esc_s      = 1'b0;
        if (state_r == ST_CLEAR) begin
            zero_en_s = 1'b1;
        end else if (accept_s) begin
            case (in_ascii)
                8'h1B: esc_s = 1'b1;
                8'h0A: begin
                    x_nxt_s = {lp_cw{1'b0}};
                    adv_s   = 1'b1;
                end
                8'h0D: x_nxt_s = {lp_cw{1'b0}};
                8'h09: begin
                    if (tab_nxt_s >= lp_cols_w) begin
                        x_nxt_s = {lp_cw{1'b0}};
                        adv_s   = 1'b1;
                    end else begin
                        x_nxt_s = tab_nxt_s[lp_cw-1:0];
                    end
                end
                8'h08, 8'h7F: begin
                    if (cur_x_r != {lp_cw{1'b0}}) begin
                        x_nxt_s  = cur_x_r - {{(lp_cw-1){1'b0}}, 1'b1};
                        wr_en_s  = 1'b1;
                        wr_col_s = cur_x_r - {{(lp_cw-1){1'b0}}, 1'b1};
                    end else begin
                        x_nxt_s = cur_x_r;
                    end
                end
                default: begin
                    if (in_ascii >= 8'h20 && in_ascii <= 8'h7E) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = {in_ascii, in_attr};
                        if (cur_x_r < lp_last_col) begin
                            x_nxt_s = cur_x_r + {{(lp_cw-1){1'b0}}, 1'b1};
                        end else begin
                            x_nxt_s = {lp_cw{1'b0}};
                            adv_s   = 1'b1;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
            endcase
        end else begin
            esc_s = 1'b0;
        end
        if (adv_s) begin
            if (cur_y_r < lp_last_row) begin
                y_nxt_s = cur_y_r + {{(lp_rw-1){1'b0}}, 1'b1};
            end else begin
                top_nxt_s  = (top_r == lp_last_row) ? {lp_rw{1'b0}}
                                                    : top_r + {{(lp_rw-1){1'b0}}, 1'b1};
                zero_en_s  = 1'b1;
                zero_row_s = top_r;
            end
        end else begin
            y_nxt_s = cur_y_r;
        end
    end

    // control FSM: sequential row clear, then stream processing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_row_r <= {lp_rw{1'b0}};
            cur_x_r   <= {lp_cw{1'b0}};
            cur_y_r   <= {lp_rw{1'b0}};
            top_r     <= {lp_rw{1'b0}};
            in_rdy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_row_r == lp_last_row) begin
                        state_r   <= ST_RUN;
                        clr_row_r <= {lp_rw{1'b0}};
                        in_rdy_r  <= 1'b1;
                    end else begin
                        clr_row_r <= clr_row_r + {{(lp_rw-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    if (esc_s) begin
                        state_r   <= ST_CLEAR;
                        clr_row_r <= {lp_rw{1'b0}};
                        cur_x_r   <= {lp_cw{1'b0}};
                        cur_y_r   <= {lp_rw{1'b0}};
                        top_r     <= {lp_rw{1'b0}};
                        in_rdy_r  <= 1'b0;
                    end else begin
                        cur_x_r <= x_nxt_s;
                        cur_y_r <= y_nxt_s;
                        top_r   <= top_nxt_s;
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_row_r <= {lp_rw{1'b0}};
                    in_rdy_r  <= 1'b0;
                end
            endcase
        end
    end

    // character storage: whole-row zeroing plus a single cell write
    always_ff @(posedge clk) begin
        if (zero_en_s) begin
            for (int c = 0; c < p_num_cols; c++) begin
                mem_r[zero_row_s][c] <= 12'h000;
            end
        end
        if (wr_en_s) begin
            mem_r[cur_phys_s][wr_col_s] <= wr_data_s;
        end
    end

    assign oob_s     = ({1'b0, read_hchar} >= lp_cols_8) || ({1'b0, read_vchar} >= lp_rows_6);
    assign rd_row_s  = phys_row(read_vchar[lp_rw-1:0], top_r);
    assign rd_cell_s = mem_r[rd_row_s][read_hchar[lp_cw-1:0]];
    assign hit_s     = !oob_s && cursor_vis_s
                       && (read_vchar[lp_rw-1:0] == cur_y_r)
                       && (read_hchar[lp_cw-1:0] == cur_x_r)
                       && (read_voffset == 4'hF) && (read_hoffset != 3'd7);

    // registered pixel read; sees storage before this cycle's write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_lit_r  <= 1'b0;
            read_attr_r <= 4'h0;
            oob_r       <= 1'b1;
        end else begin
            oob_r       <= oob_s;
            read_lit_r  <= !oob_s && (state_r == ST_RUN)
                           && (hit_s || char_lut(rd_cell_s[11:4], read_hoffset, read_voffset));
            read_attr_r <= oob_s ? 4'h0 : (hit_s ? 4'hF : rd_cell_s[3:0]);
        end
    end

endmodule
